stream_bank_arbiter: RTL

Per-stream bank arbiter downstream of the AGE unit: takes the N_AGE_PER_STREAM address/bank/lns requests one stream produces per cycle, resolves bank conflicts with per-bank round-robin, and issues registered requests to that stream's N_BANKS_PER_STREAM memory banks. It back-pressures the stream's loop/AGE logic while conflicting requests drain. It also produces per-AGE load-return steering one cycle after issue. The parent instantiates one copy per stream.

---
 rtl/mage_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_bank_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mage_pkg.sv
// rtl/mage_pkg.sv - shared widths and types for the per-stream memory arbitration slice
package mage_pkg;

    localparam int N_AGE_PER_STREAM       = 4;
    localparam int N_BANKS_PER_STREAM     = 4;
    localparam int NBIT_ADDR              = 16;
    localparam int LOG_N_AGE_PER_STREAM   = $clog2(N_AGE_PER_STREAM);
    localparam int LOG_N_BANKS_PER_STREAM = $clog2(N_BANKS_PER_STREAM);

    typedef struct packed {
        logic [NBIT_ADDR-1:0]            addr;
        logic                            we;
        logic [LOG_N_AGE_PER_STREAM-1:0] age_idx;
    } bank_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one requester, search starting at ptr_i
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Walk the requesters from ptr_i with wrap-around and take the first one set
    always_comb begin
        logic found;
        int   cand;
        found   = 1'b0;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/stream_bank_arbiter.sv
// rtl/stream_bank_arbiter.sv - per-stream bank conflict resolution, issue and load-return steering
module stream_bank_arbiter
    import mage_pkg::*;
#(
    parameter int N_AGE    = N_AGE_PER_STREAM,
    parameter int N_BANKS  = N_BANKS_PER_STREAM,
    parameter int ADDR_W   = NBIT_ADDR,
    localparam int AIW     = (N_AGE > 1) ? $clog2(N_AGE) : 1,
    localparam int BIW     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clear_i,
    input  logic [N_AGE*ADDR_W-1:0]   age_addr_i,
    input  logic [N_AGE*N_BANKS-1:0]  age_bank_i,
    input  logic [N_AGE-1:0]          age_valid_i,
    input  logic [N_AGE-1:0]          age_lns_i,
    output logic                      age_ready_o,
    output logic [N_BANKS-1:0]        bank_req_o,
    output logic [N_BANKS*ADDR_W-1:0] bank_addr_o,
    output logic [N_BANKS-1:0]        bank_we_o,
    output logic [N_BANKS*AIW-1:0]    bank_age_idx_o,
    output logic [N_AGE-1:0]          rsp_valid_o,
    output logic [N_AGE*BIW-1:0]      rsp_bank_o
);

    logic [N_AGE-1:0]   pend_q, pend_d;
    logic [ADDR_W-1:0]  lat_addr_q [N_AGE];
    logic [BIW-1:0]     lat_bank_q [N_AGE];
    logic [N_AGE-1:0]   lat_lns_q;

    logic               use_inputs;
    logic [N_AGE-1:0]   cur_valid, cur_lns;
    logic [ADDR_W-1:0]  cur_addr [N_AGE];
    logic [BIW-1:0]     cur_bank [N_AGE];

    logic [N_AGE-1:0]   bank_reqs [N_BANKS];
    logic [N_AGE-1:0]   grant     [N_BANKS];
    logic [AIW-1:0]     win_idx   [N_BANKS];
    logic [N_BANKS-1:0] win_valid;
    logic [N_AGE-1:0]   granted;
    logic [AIW-1:0]     rr_ptr_q  [N_BANKS];

    logic [N_BANKS-1:0] bank_req_q, bank_we_q;
    logic [ADDR_W-1:0]  bank_addr_q [N_BANKS];
    logic [AIW-1:0]     bank_idx_q  [N_BANKS];

    logic [N_AGE-1:0]   rsp_valid_q, rsp_valid_d;
    logic [BIW-1:0]     rsp_bank_q [N_AGE];
    logic [BIW-1:0]     rsp_bank_d [N_AGE];

    // Multi-hot bank selects resolve to the lowest set bit
    function automatic logic [BIW-1:0] lowest_idx(input logic [N_BANKS-1:0] v);
        logic [BIW-1:0] r;
        r = '0;
        for (int i = N_BANKS - 1; i >= 0; i--) begin
            if (v[i]) r = BIW'(i);
        end
        return r;
    endfunction

    assign use_inputs  = (pend_q == '0);
    assign age_ready_o = use_inputs;

    // Requests this cycle: a fresh batch when idle, otherwise the latched losers
    always_comb begin
        cur_valid = '0;
        cur_lns   = '0;
        for (int a = 0; a < N_AGE; a++) begin
            cur_addr[a] = '0;
            cur_bank[a] = '0;
            if (use_inputs) begin
                cur_valid[a] = age_valid_i[a] && (age_bank_i[a*N_BANKS +: N_BANKS] != '0);
                cur_lns[a]   = age_lns_i[a];
                cur_addr[a]  = age_addr_i[a*ADDR_W +: ADDR_W];
                cur_bank[a]  = lowest_idx(age_bank_i[a*N_BANKS +: N_BANKS]);
            end else begin
                cur_valid[a] = pend_q[a];
                cur_lns[a]   = lat_lns_q[a];
                cur_addr[a]  = lat_addr_q[a];
                cur_bank[a]  = lat_bank_q[a];
            end
        end
    end

    // Split requests per bank and collect which AGEs won somewhere
    always_comb begin
        granted = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int a = 0; a < N_AGE; a++) begin
                bank_reqs[b][a] = cur_valid[a] && (cur_bank[a] == BIW'(b));
            end
            granted = granted | grant[b];
        end
        pend_d = cur_valid & ~granted;
    end

    for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_arb
        rr_arbiter #(.N(N_AGE), .IW(AIW)) u_arb (
            .req_i   (bank_reqs[gb]),
            .ptr_i   (rr_ptr_q[gb]),
            .grant_o (grant[gb]),
            .idx_o   (win_idx[gb]),
            .valid_o (win_valid[gb])
        );
    end

    // Pending set and the batch snapshot it refers to; the snapshot only moves when a new batch is taken
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q    <= '0;
            lat_lns_q <= '0;
            for (int a = 0; a < N_AGE; a++) begin
                lat_addr_q[a] <= '0;
                lat_bank_q[a] <= '0;
            end
        end else if (clear_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (use_inputs) begin
                lat_lns_q <= cur_lns;
                for (int a = 0; a < N_AGE; a++) begin
                    lat_addr_q[a] <= cur_addr[a];
                    lat_bank_q[a] <= cur_bank[a];
                end
            end
        end
    end

    // Bank issue registers and round-robin pointers; idle banks drive zeros
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_req_q <= '0;
            bank_we_q  <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                bank_addr_q[b] <= '0;
                bank_idx_q[b]  <= '0;
                rr_ptr_q[b]    <= '0;
            end
        end else if (clear_i) begin
            bank_req_q <= '0;
            bank_we_q  <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                bank_addr_q[b] <= '0;
                bank_idx_q[b]  <= '0;
                rr_ptr_q[b]    <= '0;
            end
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                bank_req_q[b]  <= win_valid[b];
                bank_we_q[b]   <= win_valid[b] && !cur_lns[win_idx[b]];
                bank_addr_q[b] <= win_valid[b] ? cur_addr[win_idx[b]] : '0;
                bank_idx_q[b]  <= win_valid[b] ? win_idx[b] : '0;
                if (win_valid[b]) begin
                    rr_ptr_q[b] <= (win_idx[b] == AIW'(N_AGE - 1)) ? '0 : win_idx[b] + AIW'(1);
                end
            end
        end
    end

    // Loads issued last cycle steer their AGE to the bank read port now
    always_comb begin
        rsp_valid_d = '0;
        for (int a = 0; a < N_AGE; a++) rsp_bank_d[a] = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (bank_req_q[b] && !bank_we_q[b]) begin
                rsp_valid_d[bank_idx_q[b]] = 1'b1;
                rsp_bank_d[bank_idx_q[b]]  = BIW'(b);
            end
        end
    end

    // One-stage response pipeline
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= '0;
            for (int a = 0; a < N_AGE; a++) rsp_bank_q[a] <= '0;
        end else if (clear_i) begin
            rsp_valid_q <= '0;
            for (int a = 0; a < N_AGE; a++) rsp_bank_q[a] <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            for (int a = 0; a < N_AGE; a++) rsp_bank_q[a] <= rsp_bank_d[a];
        end
    end

    // Flatten registered state onto the output buses
    always_comb begin
        bank_req_o     = bank_req_q;
        bank_we_o      = bank_we_q;
        rsp_valid_o    = rsp_valid_q;
        bank_addr_o    = '0;
        bank_age_idx_o = '0;
        rsp_bank_o     = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_addr_o[b*ADDR_W +: ADDR_W] = bank_addr_q[b];
            bank_age_idx_o[b*AIW +: AIW]    = bank_idx_q[b];
        end
        for (int a = 0; a < N_AGE; a++) begin
            rsp_bank_o[a*BIW +: BIW] = rsp_bank_q[a];
        end
    end

endmodule
